// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one pipelined divider
// among NREQ requesters, results routed back by a tag pipe.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (ready one-hot)
//   req_dividend             packed dividends, slot i at [i*N +: N]
//   req_divisor              packed divisors, slot i at [i*M +: M]
//   resp_valid               one-hot result strobe, no backpressure
//   resp_merchant            quotient (all ones on divide-by-zero)
//   resp_remainder           remainder (zero on divide-by-zero)
//   resp_dz                  result came from divisor == 0
//   div_data_rdy             divider issue strobe
//   div_dividend/div_divisor divider operands
//   div_res_rdy              divider result valid
//   div_merchant/remainder   divider results
//   busy                     any operation in flight
//   seq_err                  sticky tag/result misalignment
module divider_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 21,
  parameter int M    = 13,
  parameter int LAT  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*M-1:0] req_divisor,
  output logic [NREQ-1:0]   resp_valid,
  output logic [N-1:0]      resp_merchant,
  output logic [M-1:0]      resp_remainder,
  output logic              resp_dz,
  output logic              div_data_rdy,
  output logic [N-1:0]      div_dividend,
  output logic [M-1:0]      div_divisor,
  input  logic              div_res_rdy,
  input  logic [N-1:0]      div_merchant,
  input  logic [M-1:0]      div_remainder,
  output logic              busy,
  output logic              seq_err
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_next;
  logic [IDW-1:0] grant;
  logic           any_req;
  logic           accept;
  logic [IDW:0]   scan;
  logic [N-1:0]   sel_dvd;
  logic [M-1:0]   sel_dvs;
  logic [IDW-1:0] iss_id;

  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_dz;
  logic [IDW-1:0] tag_id [LAT];

  logic           out_v;
  logic           out_dz;
  logic [IDW-1:0] out_id;

  // Scan from rr_ptr upward, wrapping at NREQ.
  // scan is one bit wider so the wrap works for
  // any NREQ, not only powers of two.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ))
        scan = scan - (IDW+1)'(NREQ);
      if (!any_req && req_valid[scan[IDW-1:0]]) begin
        grant   = scan[IDW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign accept = any_req & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant] = 1'b1;
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_dvd = req_dividend[i*N +: N];
        sel_dvs = req_divisor[i*M +: M];
      end
    end
  end

  assign rr_next = (grant == IDW'(NREQ-1)) ?
                   '0 : grant + 1'b1;

  // Issue register: operands hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      div_data_rdy <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      iss_id       <= '0;
    end else begin
      div_data_rdy <= accept;
      if (accept) begin
        rr_ptr       <= rr_next;
        div_dividend <= sel_dvd;
        div_divisor  <= sel_dvs;
        iss_id       <= grant;
      end
    end
  end

  // Stage 0 captures the issue the divider samples on
  // this edge, so stage LAT-1 lines up with res_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_dz <= '0;
      for (int s = 0; s < LAT; s++)
        tag_id[s] <= '0;
    end else begin
      tag_v  <= {tag_v[LAT-2:0], div_data_rdy};
      tag_dz <= {tag_dz[LAT-2:0], div_divisor == '0};
      tag_id[0] <= iss_id;
      for (int s = 1; s < LAT; s++)
        tag_id[s] <= tag_id[s-1];
    end
  end

  assign out_v  = tag_v[LAT-1];
  assign out_dz = tag_dz[LAT-1];
  assign out_id = tag_id[LAT-1];

  // A tag without a result (or the reverse) is
  // flagged and dropped rather than routed.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= '0;
      resp_merchant  <= '0;
      resp_remainder <= '0;
      resp_dz        <= 1'b0;
      seq_err        <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (out_v != div_res_rdy)
        seq_err <= 1'b1;
      if (out_v && div_res_rdy) begin
        resp_valid[out_id] <= 1'b1;
        resp_dz            <= out_dz;
        resp_merchant      <= out_dz ? '1 : div_merchant;
        resp_remainder     <= out_dz ? '0 : div_remainder;
      end
    end
  end

  assign busy = div_data_rdy | (|tag_v) | (|resp_valid);

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: table vectors, directed corner
// sequences and a random scoreboard run.
module tb_divider_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 21;
  localparam int M    = 13;
  localparam int LAT  = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend = '0;
  logic [NREQ*M-1:0] req_divisor = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [N-1:0]      resp_merchant;
  logic [M-1:0]      resp_remainder;
  logic              resp_dz;
  logic              div_data_rdy;
  logic [N-1:0]      div_dividend;
  logic [M-1:0]      div_divisor;
  logic              div_res_rdy;
  logic [N-1:0]      div_merchant;
  logic [M-1:0]      div_remainder;
  logic              busy;
  logic              seq_err;
  logic              spur = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  divider_arbiter #(
    .NREQ(NREQ), .N(N), .M(M), .LAT(LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_merchant (resp_merchant),
    .resp_remainder(resp_remainder),
    .resp_dz       (resp_dz),
    .div_data_rdy  (div_data_rdy),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_res_rdy   (div_res_rdy),
    .div_merchant  (div_merchant),
    .div_remainder (div_remainder),
    .busy          (busy),
    .seq_err       (seq_err)
  );

  // Divider stand-in: LAT-cycle delay line of plain
  // arithmetic results. Divide-by-zero yields junk
  // that the arbiter has to override.
  logic [LAT-1:0] dv_v;
  logic [N-1:0]   dv_q [LAT];
  logic [M-1:0]   dv_r [LAT];

  always @(posedge clk) begin
    if (rst) begin
      dv_v <= '0;
    end else begin
      dv_v <= {dv_v[LAT-2:0], div_data_rdy};
      for (int i = LAT-1; i > 0; i--) begin
        dv_q[i] <= dv_q[i-1];
        dv_r[i] <= dv_r[i-1];
      end
      if (div_divisor == '0) begin
        dv_q[0] <= '0;
        dv_r[0] <= 13'h05A;
      end else begin
        dv_q[0] <= div_dividend / N'(div_divisor);
        dv_r[0] <= M'(div_dividend % N'(div_divisor));
      end
    end
  end

  assign div_res_rdy   = dv_v[LAT-1] | spur;
  assign div_merchant  = dv_q[LAT-1];
  assign div_remainder = dv_r[LAT-1];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accept is due back exactly
  // LAT+2 cycles after the cycle it was offered in.
  typedef struct {
    int            due;
    int            id;
    logic [N-1:0]  q;
    logic [M-1:0]  r;
    logic          dz;
  } exp_t;

  exp_t            sbq[$];
  int              rr_m = 0;
  int              m_g;
  exp_t            m_e;
  logic [NREQ-1:0] m_er;
  logic [NREQ-1:0] m_ev;
  logic [N-1:0]    m_a;
  logic [M-1:0]    m_b;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, sbq.size() != 0);
      m_ev = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        m_e = sbq.pop_front();
        m_ev[m_e.id] = 1'b1;
        chk("sb_merchant", resp_merchant, m_e.q);
        chk("sb_remainder", resp_remainder, m_e.r);
        chk("sb_dz", resp_dz, m_e.dz);
      end
      chk("resp_valid", resp_valid, m_ev);
      m_g  = -1;
      m_er = '0;
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_g < 0 && req_valid[(rr_m + k) % NREQ])
            m_g = (rr_m + k) % NREQ;
        end
      end
      if (m_g >= 0) m_er[m_g] = 1'b1;
      chk("req_ready", req_ready, m_er);
      if (rst) begin
        sbq.delete();
        rr_m = 0;
      end else if (m_g >= 0) begin
        m_a = req_dividend[m_g*N +: N];
        m_b = req_divisor[m_g*M +: M];
        if (m_b == 0)
          sbq.push_back('{cyc + LAT + 2, m_g,
                          {N{1'b1}}, '0, 1'b1});
        else
          sbq.push_back('{cyc + LAT + 2, m_g,
                          m_a / N'(m_b),
                          M'(m_a % N'(m_b)), 1'b0});
        rr_m = (m_g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int id,
                        input logic [N-1:0] a,
                        input logic [M-1:0] b);
    req_dividend[id*N +: N] = a;
    req_divisor[id*M +: M]  = b;
  endtask

  typedef struct {
    int           id;
    logic [N-1:0] dvd;
    logic [M-1:0] dvs;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
  } vec_t;

  vec_t            tbl[8];
  logic [NREQ-1:0] oh;
  logic [NREQ-1:0] rq[$];
  int              rc[$];
  int              offs[3];
  int              c0;
  int              n;
  bit              got;

  initial begin
    tbl[0] = '{0, 21'd1000,    13'd7,    21'd142,    13'd6,   1'b0};
    tbl[1] = '{2, 21'd55,      13'd0,    21'h1FFFFF, 13'd0,   1'b1};
    tbl[2] = '{1, 21'd2097151, 13'd8191, 21'd256,    13'd255, 1'b0};
    tbl[3] = '{3, 21'd5,       13'd9,    21'd0,      13'd5,   1'b0};
    tbl[4] = '{1, 21'd8191,    13'd1,    21'd8191,   13'd0,   1'b0};
    tbl[5] = '{0, 21'd0,       13'd3,    21'd0,      13'd0,   1'b0};
    tbl[6] = '{3, 21'd100000,  13'd13,   21'd7692,   13'd4,   1'b0};
    tbl[7] = '{0, 21'd2097151, 13'd0,    21'h1FFFFF, 13'd0,   1'b1};
    offs = '{0, 1, 3};

    // Reset state, with every requester asking.
    req_valid = '1;
    repeat (3) tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_issue", div_data_rdy, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_data", {resp_merchant, resp_remainder, resp_dz}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_err", seq_err, 0);
    tick();
    rst = 1'b0;
    req_valid = '0;

    // Single operations from the table.
    foreach (tbl[v]) begin
      set_op(tbl[v].id, tbl[v].dvd, tbl[v].dvs);
      oh = '0;
      oh[tbl[v].id] = 1'b1;
      req_valid = oh;
      @(negedge clk);
      chk("vec_ready", req_ready, oh);
      tick();
      req_valid = '0;
      n   = 0;
      got = 1'b0;
      for (int k = 0; k < LAT + 10 && !got; k++) begin
        @(negedge clk);
        n++;
        if (n == 1)
          chk("vec_issue",
              {div_data_rdy, div_dividend, div_divisor},
              {1'b1, tbl[v].dvd, tbl[v].dvs});
        if (resp_valid != 0) got = 1'b1;
      end
      chk("vec_latency", n, LAT + 2);
      chk("vec_resp_valid", resp_valid, oh);
      chk("vec_merchant", resp_merchant, tbl[v].q);
      chk("vec_remainder", resp_remainder, tbl[v].r);
      chk("vec_dz", resp_dz, tbl[v].dz);
      tick();
    end

    // Round-robin from rr_ptr = 0, all requesters held.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_op(i, N'(1000 * (i + 3) + i), M'(3 + 2 * i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      oh = '0;
      oh[k % NREQ] = 1'b1;
      chk("rr_grant", req_ready, oh);
      tick();
    end
    req_valid = '0;
    rq.delete();
    rc.delete();
    for (int k = 0; k < LAT + 12; k++) begin
      @(negedge clk);
      if (resp_valid != 0) begin
        rq.push_back(resp_valid);
        rc.push_back(cyc);
      end
    end
    chk("rr_count", rq.size(), 8);
    for (int k = 0; k < rq.size(); k++) begin
      oh = '0;
      oh[k % NREQ] = 1'b1;
      chk("rr_order", rq[k], oh);
      chk("rr_spacing", rc[k] - rc[0], k);
    end

    // Back-to-back plus a gap on requester 1.
    tick();
    c0 = cyc;
    set_op(1, 21'd777, 13'd5);
    req_valid = 4'b0010;
    tick();
    set_op(1, 21'd778, 13'd5);
    tick();
    req_valid = '0;
    tick();
    set_op(1, 21'd780, 13'd5);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rc.delete();
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (resp_valid[1]) rc.push_back(cyc);
      if (cyc == c0 + LAT + 5)
        chk("b2b_busy_last", busy, 1);
      if (cyc == c0 + LAT + 6)
        chk("b2b_busy_drop", busy, 0);
    end
    chk("b2b_count", rc.size(), 3);
    for (int k = 0; k < rc.size() && k < 3; k++)
      chk("b2b_timing", rc[k], c0 + LAT + 2 + offs[k]);

    // Reset in the middle of three in-flight ops.
    tick();
    c0 = cyc;
    for (int i = 0; i < NREQ; i++)
      set_op(i, N'(4000 + i), 13'd9);
    req_valid = 4'b1011;
    repeat (3) tick();
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
    end
    chk("midrst_busy", busy, 0);
    chk("midrst_seq_err", seq_err, 0);
    tick();
    req_valid = '1;
    @(negedge clk);
    chk("midrst_rr_ptr", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (LAT + 4) tick();

    // Spurious result with no tag in flight.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mis_seq_err", seq_err, 1);
      chk("mis_no_resp", resp_valid, 0);
    end
    do_reset();
    @(negedge clk);
    chk("mis_cleared", seq_err, 0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      tick();
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0)
          set_op(i, N'($urandom), '0);
        else
          set_op(i, N'($urandom), M'($urandom));
      end
    end
    tick();
    req_valid = '0;
    repeat (LAT + 5) tick();
    @(negedge clk);
    chk("rand_drained", sbq.size(), 0);
    chk("rand_seq_err", seq_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one pipelined restoring divider (N-bit dividend, M-bit divisor, one result per cycle, fixed latency LAT) among NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- A tag pipeline tracks requester ID and divide-by-zero status alongside the divider.
- Each result is routed back to the requester that issued it.
- Sits between the requester blocks and the divider; drives the divider's data_rdy/dividend/divisor and consumes res_rdy/merchant/remainder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 21, dividend and quotient width.
- M, 13, divisor and remainder width.
- LAT, 21, divider latency in cycles from data_rdy to res_rdy; must equal the divider stage count (N).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_dividend  in  NREQ*N  packed dividends; requester i is at [i*N +: N].
- req_divisor  in  NREQ*M  packed divisors; requester i is at [i*M +: M].
- resp_valid  out  NREQ  one-cycle result strobe, one-hot or zero.
- resp_merchant  out  N  quotient.
- resp_remainder  out  M  remainder.
- resp_dz  out  1  result came from divisor==0.
- div_data_rdy  out  1  divider enable.
- div_dividend  out  N  operand to divider.
- div_divisor  out  M  operand to divider.
- div_res_rdy  in  1  divider result valid.
- div_merchant  in  N  divider quotient.
- div_remainder  in  M  divider remainder.
- busy  out  1  any operation in flight.
- seq_err  out  1  sticky tag/result misalignment flag.

Behaviour:
- Reset values: all registered outputs 0; rr_ptr=0; tag pipe cleared; seq_err=0. The divider must share this reset.
- Arbitration (combinational):
  - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready = onehot(grant) when any req_valid is set, else 0.
  - req_ready is never asserted during rst.
- Pointer update: on an accepted request, rr_ptr <= grant+1 mod NREQ; otherwise rr_ptr holds.
- Issue register:
  - Accept at cycle T -> div_data_rdy=1 at T+1, with div_dividend/div_divisor = the granted operands latched at T.
  - With no accept, div_data_rdy=0 and the operand registers hold.
  - Back-to-back accepts are allowed every cycle; there is no stall.
- Tag pipe:
  - LAT-deep shift register of {v, id[clog2(NREQ)-1:0], dz}.
  - Stage 0 is loaded in lockstep with div_data_rdy: v=div_data_rdy, dz=(issued divisor==0).
  - The tag at stage LAT-1 is aligned with div_res_rdy.
- Response register, one cycle after div_res_rdy (handshake at T -> resp at T+LAT+2):
  - If tag.v and div_res_rdy: resp_valid[tag.id]=1 and resp_dz=tag.dz.
  - If dz=0: merchant/remainder = divider outputs.
  - If dz=1: resp_merchant={N{1'b1}}, resp_remainder=0.
  - Otherwise resp_valid=0 and the data registers hold.
- Requesters must always accept resp_valid; there is no response backpressure.
- seq_err: set when tag.v != div_res_rdy at the output stage; cleared only by rst. On a mismatch no response is produced.
- busy = div_data_rdy | any tag.v | any resp_valid.
- Simultaneous accept and result in the same cycle are independent; both proceed.
- Reset mid-operation: in-flight tags are discarded and no resp_valid is issued for them.
- Width rules: operands pass through unmodified; no sign handling (unsigned only).

Test Plan:
- Single op: req0 valid, dividend=1000, divisor=7 at T -> div_data_rdy at T+1; resp_valid=0001 at T+LAT+2 with merchant=142, remainder=6, dz=0.
- Round-robin: all 4 requesters held valid for 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle, each with its requester's correct quotient and remainder.
- Divide-by-zero: req2 with divisor=0, dividend=55 -> resp_valid=0100, dz=1, merchant=0x1FFFFF, remainder=0.
- Back-to-back plus idle gaps: req1 issues at cycles 0,1,3 -> resp_valid[1] at LAT+2, LAT+3, LAT+5; busy drops the cycle after the last response.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle at T+5 -> no resp_valid afterwards; busy=0, rr_ptr=0, seq_err=0.
- Misalignment: force a spurious div_res_rdy with no tag -> seq_err=1 and held until rst; resp_valid stays 0.
